// File: rtl/rob_commit.sv
// In-order reorder buffer: dispatch allocates at the tail, execution units complete
// entries out of order by tag, and the head drains completed entries in program order.
module rob_commit #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [DEST_W-1:0] alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_data,
  output logic              commit_valid,
  input  logic              commit_ready,
  output logic [DEST_W-1:0] commit_dest,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [TAG_W:0]    count,
  output logic              empty,
  output logic              full
);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  done_q;
  logic [DEST_W-1:0] dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [TAG_W-1:0]  head_q;
  logic [TAG_W-1:0]  tail_q;
  logic [TAG_W:0]    count_q;

  logic alloc_fire;
  logic wb_fire;
  logic commit_fire;

  // Every output decodes registered state only; no input reaches an output combinationally.
  assign full         = (count_q == (TAG_W+1)'(DEPTH));
  assign empty        = (count_q == '0);
  assign count        = count_q;
  assign alloc_ready  = !full;
  assign alloc_tag    = tail_q;
  assign commit_valid = valid_q[head_q] && done_q[head_q];
  assign commit_dest  = dest_q[head_q];
  assign commit_data  = data_q[head_q];
  assign commit_tag   = head_q;

  assign alloc_fire  = alloc_valid && !full;
  assign wb_fire     = wb_valid && valid_q[wb_tag] && !done_q[wb_tag];
  assign commit_fire = commit_valid && commit_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the entry arrays are reset (not left as plain RAM) because the commit
      // outputs must read as zero straight out of reset and after a flush.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking updates here are ordered on purpose: the allocation comes
      // last so it overrides a commit clearing the same slot in the same cycle.
      if (commit_fire) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + TAG_W'(1);
      end
      if (wb_fire) begin
        done_q[wb_tag] <= 1'b1;
        data_q[wb_tag] <= wb_data;
      end
      if (alloc_fire) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        dest_q[tail_q]  <= alloc_dest;
        tail_q          <= tail_q + TAG_W'(1);
      end
      if (alloc_fire && !commit_fire)
        count_q <= count_q + (TAG_W+1)'(1);
      else if (commit_fire && !alloc_fire)
        count_q <= count_q - (TAG_W+1)'(1);
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed self-checking bench for rob_commit; outputs are sampled 1 time unit after
// each rising edge, inputs are changed at the same point.
module tb_rob_commit;

  localparam int DEPTH  = 8;
  localparam int TAG_W  = 3;
  localparam int DATA_W = 32;
  localparam int DEST_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              alloc_valid = 1'b0;
  logic [DEST_W-1:0] alloc_dest = '0;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              wb_valid = 1'b0;
  logic [TAG_W-1:0]  wb_tag = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              commit_valid;
  logic              commit_ready = 1'b0;
  logic [DEST_W-1:0] commit_dest;
  logic [DATA_W-1:0] commit_data;
  logic [TAG_W-1:0]  commit_tag;
  logic [TAG_W:0]    count;
  logic              empty;
  logic              full;

  int n_checks = 0;
  int n_errors = 0;

  rob_commit #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .DEST_W(DEST_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_dest(commit_dest),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; alloc_valid = 1'b0; alloc_dest = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_data = '0; commit_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".alloc_ready"}, 32'(alloc_ready), 1);
    check({tag, ".empty"}, 32'(empty), 1);
    check({tag, ".full"}, 32'(full), 0);
    check({tag, ".commit_valid"}, 32'(commit_valid), 0);
    check({tag, ".alloc_tag"}, 32'(alloc_tag), 0);
    check({tag, ".commit_tag"}, 32'(commit_tag), 0);
    check({tag, ".commit_dest"}, 32'(commit_dest), 0);
    check({tag, ".commit_data"}, commit_data, 0);
    check({tag, ".count"}, 32'(count), 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic alloc_n(input int n, input int dest_base);
    alloc_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      alloc_dest = DEST_W'(dest_base + i);
      step();
    end
    alloc_valid = 1'b0;
  endtask

  task automatic writeback(input int tag, input logic [31:0] data);
    wb_valid = 1'b1; wb_tag = TAG_W'(tag); wb_data = data;
    step();
    wb_valid = 1'b0;
  endtask

  initial begin
    #2;
    check_reset_outputs("por");
    do_reset();
    check_reset_outputs("rst");

    // In-order completion drains on consecutive cycles.
    alloc_n(3, 1);
    check("t1.count3", 32'(count), 3);
    check("t1.alloc_tag", 32'(alloc_tag), 3);
    commit_ready = 1'b1;
    writeback(0, 32'hA);
    check("t1.c0.valid", 32'(commit_valid), 1);
    check("t1.c0.dest", 32'(commit_dest), 1);
    check("t1.c0.data", commit_data, 32'hA);
    writeback(1, 32'hB);
    check("t1.c1.valid", 32'(commit_valid), 1);
    check("t1.c1.dest", 32'(commit_dest), 2);
    check("t1.c1.data", commit_data, 32'hB);
    writeback(2, 32'hC);
    check("t1.c2.valid", 32'(commit_valid), 1);
    check("t1.c2.dest", 32'(commit_dest), 3);
    check("t1.c2.data", commit_data, 32'hC);
    step();
    check("t1.end.valid", 32'(commit_valid), 0);
    check("t1.end.count", 32'(count), 0);
    check("t1.end.empty", 32'(empty), 1);

    // Out-of-order completion: nothing commits until the oldest entry is done.
    do_reset();
    alloc_n(3, 7);
    commit_ready = 1'b1;
    writeback(2, 32'h22);
    check("t2.after_wb2", 32'(commit_valid), 0);
    writeback(1, 32'h11);
    check("t2.after_wb1", 32'(commit_valid), 0);
    writeback(0, 32'h00);
    check("t2.c0.valid", 32'(commit_valid), 1);
    check("t2.c0.tag", 32'(commit_tag), 0);
    check("t2.c0.dest", 32'(commit_dest), 7);
    step();
    check("t2.c1.tag", 32'(commit_tag), 1);
    check("t2.c1.data", commit_data, 32'h11);
    check("t2.c1.valid", 32'(commit_valid), 1);
    step();
    check("t2.c2.tag", 32'(commit_tag), 2);
    check("t2.c2.data", commit_data, 32'h22);
    check("t2.c2.dest", 32'(commit_dest), 9);
    step();
    check("t2.end.empty", 32'(empty), 1);

    // Full: ninth allocation ignored; commit while full does not bypass to allocate.
    do_reset();
    alloc_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("t3.alloc_tag%0d", i), 32'(alloc_tag), i);
      alloc_dest = DEST_W'(10 + i);
      step();
    end
    check("t3.full", 32'(full), 1);
    check("t3.alloc_ready", 32'(alloc_ready), 0);
    check("t3.count8", 32'(count), 8);
    step();
    check("t3.ninth_ignored", 32'(count), 8);
    wb_valid = 1'b1; wb_tag = 0; wb_data = 32'h100;
    step();
    wb_valid = 1'b0;
    check("t3.head_done", 32'(commit_valid), 1);
    check("t3.head_dest", 32'(commit_dest), 10);
    commit_ready = 1'b1; alloc_dest = 5'd21;
    step();
    check("t3.no_bypass.count", 32'(count), 7);
    check("t3.no_bypass.ready", 32'(alloc_ready), 1);
    check("t3.no_bypass.tag", 32'(alloc_tag), 0);
    check("t3.next_head", 32'(commit_tag), 1);
    commit_ready = 1'b0;
    step();
    alloc_valid = 1'b0;
    check("t3.realloc.count", 32'(count), 8);
    check("t3.realloc.tail", 32'(alloc_tag), 1);
    check("t3.realloc.full", 32'(full), 1);

    // Writeback to an unallocated entry is dropped; a second writeback does not overwrite.
    do_reset();
    writeback(5, 32'hDEAD);
    alloc_n(6, 0);
    check("t4.count6", 32'(count), 6);
    check("t4.none_done", 32'(commit_valid), 0);
    for (int i = 0; i < 5; i++) writeback(i, 32'h200 + 32'(i));
    commit_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4.drain%0d.tag", i), 32'(commit_tag), i);
      check($sformatf("t4.drain%0d.data", i), commit_data, 32'h200 + 32'(i));
      step();
    end
    commit_ready = 1'b0;
    check("t4.tag5.head", 32'(commit_tag), 5);
    check("t4.tag5.not_done", 32'(commit_valid), 0);
    check("t4.tag5.count", 32'(count), 1);
    writeback(5, 32'h55);
    check("t4.tag5.done", 32'(commit_valid), 1);
    check("t4.tag5.data", commit_data, 32'h55);
    writeback(5, 32'h99);
    check("t4.tag5.no_overwrite", commit_data, 32'h55);
    check("t4.tag5.hold_valid", 32'(commit_valid), 1);
    commit_ready = 1'b1;
    step();
    check("t4.end.count", 32'(count), 0);

    // Flush wins over simultaneous allocate, writeback and commit.
    do_reset();
    alloc_n(5, 3);
    writeback(0, 32'h77);
    writeback(1, 32'h88);
    check("t5.pre.valid", 32'(commit_valid), 1);
    flush = 1'b1; alloc_valid = 1'b1; alloc_dest = 5'd30; commit_ready = 1'b1;
    wb_valid = 1'b1; wb_tag = 3'd2; wb_data = 32'h99;
    step();
    idle_inputs();
    check_reset_outputs("t5.flush");

    // Streaming: entry i allocated in cycle i, completed in cycle i+1, committed in cycle i+2.
    do_reset();
    commit_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = DEST_W'(i + 3);
      wb_valid    = (i > 0);
      wb_tag      = TAG_W'(i - 1);
      wb_data     = 32'h1000 + 32'(i - 1);
      step();
      if (i > 0) begin
        check($sformatf("t6.%0d.valid", i), 32'(commit_valid), 1);
        check($sformatf("t6.%0d.tag", i), 32'(commit_tag), (i - 1) % DEPTH);
        check($sformatf("t6.%0d.data", i), commit_data, 32'h1000 + 32'(i - 1));
        check($sformatf("t6.%0d.dest", i), 32'(commit_dest), (i + 2) % 32);
        check($sformatf("t6.%0d.count", i), 32'(count), 2);
      end
    end
    // Asynchronous reset mid-stream, checked well before the next rising edge.
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("t6.async_rst");
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
